// File: rtl/hbc_pkg.sv
// hbc_pkg: shared constants and helpers for the HyperBus controller.
//   FSM state encodings, command/address (CA) bit positions, CA builder and byte selector.
package hbc_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CSS  = 3'd1;
  localparam logic [2:0] ST_CA   = 3'd2;
  localparam logic [2:0] ST_LAT  = 3'd3;
  localparam logic [2:0] ST_WDAT = 3'd4;
  localparam logic [2:0] ST_RDAT = 3'd5;
  localparam logic [2:0] ST_CSH  = 3'd6;
  localparam logic [2:0] ST_RCV  = 3'd7;

  localparam int unsigned CA_RW    = 47;
  localparam int unsigned CA_AS    = 46;
  localparam int unsigned CA_BT    = 45;
  localparam int unsigned CA_BYTES = 6;

  // Linear-burst, memory-space command word for a word address.
  function automatic logic [47:0] build_ca(input logic rw, input logic [31:0] addr);
    logic [47:0] ca;
    ca        = '0;
    ca[CA_RW] = rw;
    ca[CA_AS] = 1'b0;
    ca[CA_BT] = 1'b1;
    ca[44:16] = addr[31:3];
    ca[2:0]   = addr[2:0];
    return ca;
  endfunction

  // Byte idx of the CA word, most significant byte first.
  function automatic logic [7:0] ca_byte(input logic [47:0] ca, input logic [2:0] idx);
    logic [47:0] sh;
    sh = ca << {idx, 3'b000};
    return sh[47:40];
  endfunction

endpackage

// File: rtl/hbc_rd_capture.sv
// hbc_rd_capture: read-side byte capture for the HyperBus controller.
//   clk, rst_n      : clock, async active-low reset
//   en              : high while the sequencer is in the read-data phase
//   dq, rwds        : pad inputs (registered once here)
//   word_c          : a low byte is being captured this cycle (word complete)
//   timeout_c       : no RWDS change for RD_TIMEOUT cycles
//   rd_data/valid   : registered word and its one-cycle strobe
//   rd_err          : registered one-cycle timeout strobe
module hbc_rd_capture #(
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  dq,
  input  logic        rwds,
  output logic        word_c,
  output logic        timeout_c,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_err
);

  localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

  logic [7:0]    dq_r;
  logic [7:0]    hi_q;
  logic          rwds_r;
  logic          rwds_rr;
  logic [TW-1:0] tmo;
  logic          change_c;

  // A byte arrives on every transition of the registered RWDS; rising = high byte.
  assign change_c  = en && (rwds_r != rwds_rr);
  assign word_c    = change_c && !rwds_r;
  assign timeout_c = en && !change_c && (tmo == TW'(RD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_r     <= '0;
      hi_q     <= '0;
      rwds_r   <= 1'b0;
      rwds_rr  <= 1'b0;
      tmo      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      dq_r     <= dq;
      rwds_r   <= rwds;
      rwds_rr  <= rwds_r;
      rd_valid <= word_c;
      rd_err   <= timeout_c;
      if (!en || change_c) tmo <= '0;
      else                 tmo <= tmo + TW'(1);
      if (change_c && rwds_r) hi_q <= dq_r;
      if (word_c) rd_data <= {hi_q, dq_r};
    end
  end

endmodule

// File: rtl/hbc_ctrl.sv
// hbc_ctrl: HyperBus transaction sequencer feeding the hbc_io pad block.
//   clk, rst_n                 : clock, async active-low reset
//   req_*                      : burst request (rw, word addr, len-1) with valid/ready
//   wr_data/wr_strb/wr_ready   : write word stream, one word per wr_ready pulse
//   rd_data/rd_valid/rd_err    : read word stream and timeout strobe
//   CS_n, CK                   : bus chip select and clock phase
//   DQ_o/DQ_de/DQ_i            : pad data out/enable/in
//   RWDS_o/RWDS_de/RWDS_i      : pad RWDS out/enable/in
module hbc_ctrl
  import hbc_pkg::*;
#(
  parameter int unsigned LATENCY_CLKS  = 6,
  parameter int unsigned RD_TIMEOUT    = 64,
  parameter int unsigned RECOVERY_CLKS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_strb,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_err,
  output logic        CS_n,
  output logic        CK,
  output logic [7:0]  DQ_o,
  output logic        DQ_de,
  input  logic [7:0]  DQ_i,
  output logic        RWDS_o,
  output logic        RWDS_de,
  input  logic        RWDS_i
);

  localparam int unsigned LCW = $clog2(4 * LATENCY_CLKS + 1);
  localparam int unsigned RCW = $clog2(RECOVERY_CLKS + 1);
  localparam int unsigned CW  = (LCW > RCW) ? LCW : RCW;

  logic [2:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d, lat_last;
  logic [2:0]    byte_idx, byte_d;
  logic [8:0]    word_cnt, word_d;
  logic          rw_q, dbl_q;
  logic [7:0]    len_q;
  logic [47:0]   ca_q;
  logic          cs_n_q, ck_q, dq_de_q, rwds_q, rwds_de_q, req_ready_q, wr_ready_q;
  logic [7:0]    dq_q;
  logic          cs_n_d, ck_d, dq_de_d, rwds_d, rwds_de_d, req_ready_d, wr_ready_d;
  logic [7:0]    dq_d;
  logic          hs_c, wr_hi_c, word_c, timeout_c;

  assign hs_c     = (state == ST_IDLE) && req_valid && req_ready_q;
  // Latency is counted from the first CA cycle; doubled when RWDS was high during CA.
  assign lat_last = dbl_q ? CW'(4 * LATENCY_CLKS - 1) : CW'(2 * LATENCY_CLKS - 1);
  // The high byte goes out in the wr_ready cycle itself, so it bypasses the output register.
  assign wr_hi_c  = (state == ST_WDAT) && ck_q;

  assign req_ready = req_ready_q;
  assign wr_ready  = wr_ready_q;
  assign CS_n      = cs_n_q;
  assign CK        = ck_q;
  assign DQ_de     = dq_de_q;
  assign RWDS_de   = rwds_de_q;
  assign DQ_o      = wr_hi_c ? wr_data[15:8] : dq_q;
  assign RWDS_o    = wr_hi_c ? ~wr_strb[1] : rwds_q;

  hbc_rd_capture #(.RD_TIMEOUT(RD_TIMEOUT)) u_rd (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state == ST_RDAT),
    .dq        (DQ_i),
    .rwds      (RWDS_i),
    .word_c    (word_c),
    .timeout_c (timeout_c),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_err    (rd_err)
  );

  // Next state, counters, and the registered outputs for the state being entered.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    byte_d  = byte_idx;
    word_d  = word_cnt;
    case (state)
      ST_IDLE: if (hs_c) state_d = ST_CSS;
      ST_CSS: begin
        state_d = ST_CA;
        byte_d  = '0;
        cnt_d   = '0;
      end
      ST_CA: begin
        cnt_d  = cnt + CW'(1);
        byte_d = byte_idx + 3'd1;
        if (byte_idx == 3'(CA_BYTES - 1)) begin
          word_d = '0;
          if (cnt == lat_last) state_d = rw_q ? ST_RDAT : ST_WDAT;
          else                 state_d = ST_LAT;
        end
      end
      ST_LAT: begin
        cnt_d = cnt + CW'(1);
        if (cnt == lat_last) begin
          state_d = rw_q ? ST_RDAT : ST_WDAT;
          word_d  = '0;
        end
      end
      ST_WDAT: begin
        if (!ck_q) begin
          if (word_cnt == {1'b0, len_q}) state_d = ST_CSH;
          else                           word_d  = word_cnt + 9'd1;
        end
      end
      ST_RDAT: begin
        if (timeout_c) state_d = ST_CSH;
        else if (word_c) begin
          if (word_cnt == {1'b0, len_q}) state_d = ST_CSH;
          else                           word_d  = word_cnt + 9'd1;
        end
      end
      ST_CSH: begin
        state_d = ST_RCV;
        cnt_d   = '0;
      end
      ST_RCV: begin
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(RECOVERY_CLKS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cs_n_d      = 1'b1;
    ck_d        = 1'b0;
    dq_d        = '0;
    dq_de_d     = 1'b0;
    rwds_d      = 1'b0;
    rwds_de_d   = 1'b0;
    wr_ready_d  = 1'b0;
    // Ready only from the second IDLE cycle, so recovery spans RECOVERY_CLKS+1 not-ready cycles.
    req_ready_d = (state_d == ST_IDLE) && (state == ST_IDLE);
    case (state_d)
      ST_CSS, ST_CSH: cs_n_d = 1'b0;
      ST_CA: begin
        cs_n_d  = 1'b0;
        ck_d    = ~ck_q;
        dq_de_d = 1'b1;
        dq_d    = ca_byte(ca_q, byte_d);
      end
      ST_LAT, ST_RDAT: begin
        cs_n_d = 1'b0;
        ck_d   = ~ck_q;
      end
      ST_WDAT: begin
        cs_n_d     = 1'b0;
        ck_d       = ~ck_q;
        dq_de_d    = 1'b1;
        rwds_de_d  = 1'b1;
        wr_ready_d = ~ck_q;
        // Leaving the high-byte cycle: hold the low byte of the word just consumed.
        if (ck_q) begin
          dq_d   = wr_data[7:0];
          rwds_d = ~wr_strb[0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      byte_idx    <= '0;
      word_cnt    <= '0;
      rw_q        <= 1'b0;
      dbl_q       <= 1'b0;
      len_q       <= '0;
      ca_q        <= '0;
      cs_n_q      <= 1'b1;
      ck_q        <= 1'b0;
      dq_q        <= '0;
      dq_de_q     <= 1'b0;
      rwds_q      <= 1'b0;
      rwds_de_q   <= 1'b0;
      req_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      byte_idx    <= byte_d;
      word_cnt    <= word_d;
      cs_n_q      <= cs_n_d;
      ck_q        <= ck_d;
      dq_q        <= dq_d;
      dq_de_q     <= dq_de_d;
      rwds_q      <= rwds_d;
      rwds_de_q   <= rwds_de_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      if (hs_c) begin
        rw_q  <= req_rw;
        len_q <= req_len;
        ca_q  <= build_ca(req_rw, req_addr);
        dbl_q <= 1'b0;
      end
      if (state == ST_CA && byte_idx == 3'd2) dbl_q <= RWDS_i;
    end
  end

endmodule
